spw_axil_responder: RTL and testbench

AXI4-Lite slave that terminates the register accesses issued by the processor-side master of the SpaceWire-light AXI peripheral. Provides four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC, honours byte strobes, and exports the register contents plus per-register write strobes to the SpaceWire core. Reads return the last written value; the block's acceptance test is write-then-read-back.

---
 rtl/spw_axil_pkg.sv | 36 +++
 rtl/spw_axil_wr_ctrl.sv | 92 +++++++++
 rtl/spw_axil_responder.sv | 127 ++++++++++++
 tb/tb_spw_axil_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spw_axil_pkg.sv
// Shared types and helpers for the SpaceWire-light AXI4-Lite register responder.
// Holds response codes, register indices, FSM state types and the byte-strobe merge.
package spw_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_REGS  = 4;
  localparam int REG_CTRL  = 0;
  localparam int REG_STAT  = 1;
  localparam int REG_TXCFG = 2;
  localparam int REG_RXCFG = 3;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Byte lane k of the result comes from new_val where strb[k] is set, else from old_val.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/spw_axil_wr_ctrl.sv
// AXI4-Lite write channel: independent AW/W holding registers and the write-response FSM.
// Presents a one-cycle commit strobe with the held index, data and byte strobes.
//
// state  | meaning
// W_IDLE | collecting AW and W; commits as soon as both are held
// W_RESP | BVALID asserted, waiting for BREADY
module spw_axil_wr_ctrl
  import spw_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  aw_idx,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_valid,
  output logic        w_ready,
  output logic        b_valid,
  input  logic        b_ready,
  output logic        commit,
  output logic [1:0]  commit_idx,
  output logic [31:0] commit_data,
  output logic [3:0]  commit_strb
);

  wr_state_t   state, state_nxt;
  logic        aw_held, w_held;
  logic [1:0]  idx_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;

  assign b_valid     = (state == W_RESP);
  assign aw_ready    = !aw_held && !b_valid;
  assign w_ready     = !w_held && !b_valid;
  assign commit_idx  = idx_q;
  assign commit_data = data_q;
  assign commit_strb = strb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= W_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      W_IDLE: begin
        if (aw_held && w_held) begin
          commit    = 1'b1;
          state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (b_ready) begin
          state_nxt = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  // Ready is low while a beat is held, so a capture never coincides with the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (aw_valid && aw_ready) begin
        aw_held <= 1'b1;
        idx_q   <= aw_idx;
      end
      if (w_valid && w_ready) begin
        w_held <= 1'b1;
        data_q <= w_data;
        strb_q <= w_strb;
      end
    end
  end

endmodule

// File: rtl/spw_axil_responder.sv
// AXI4-Lite slave terminating the SpaceWire-light register window: four 32-bit registers,
// strobe-aware writes, registered reads, and per-register commit pulses to the core.
//
// state  | meaning
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high with latched RDATA, waiting for RREADY
module spw_axil_responder
  import spw_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [127:0]                    cfg_regs,
  output logic [3:0]                      cfg_wr
);

  logic [31:0] regs_q [NUM_REGS];
  logic        commit;
  logic [1:0]  commit_idx;
  logic [31:0] commit_data;
  logic [3:0]  commit_strb;
  rd_state_t   r_state, r_state_nxt;
  logic [31:0] rdata_q;
  logic        unused_ok;

  // Byte-offset bits and protection attributes carry no meaning in this window.
  assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT};

  spw_axil_wr_ctrl u_wr_ctrl (
    .clk         (ACLK),
    .rst         (ARESET),
    .aw_idx      (S_AXI_AWADDR[3:2]),
    .aw_valid    (S_AXI_AWVALID),
    .aw_ready    (S_AXI_AWREADY),
    .w_data      (S_AXI_WDATA),
    .w_strb      (S_AXI_WSTRB),
    .w_valid     (S_AXI_WVALID),
    .w_ready     (S_AXI_WREADY),
    .b_valid     (S_AXI_BVALID),
    .b_ready     (S_AXI_BREADY),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      cfg_wr <= '0;
    end else begin
      if (commit) begin
        regs_q[commit_idx] <= strb_merge(regs_q[commit_idx], commit_data, commit_strb);
        cfg_wr             <= 4'b0001 << commit_idx;
      end else begin
        cfg_wr <= '0;
      end
    end
  end

  assign cfg_regs = {regs_q[REG_RXCFG], regs_q[REG_TXCFG], regs_q[REG_STAT], regs_q[REG_CTRL]};

  assign S_AXI_ARREADY = (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Sampled before any same-edge commit lands, so a colliding read returns the old value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rdata_q <= regs_q[S_AXI_ARADDR[3:2]];
    end
  end

endmodule

// File: tb/tb_spw_axil_responder.sv
// Self-checking bench for spw_axil_responder: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the register window.
module tb_spw_axil_responder;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [3:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b0;
  logic [3:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b0;
  logic [127:0] cfg_regs;
  logic [3:0]   cfg_wr;

  int tests = 0;
  int fails = 0;

  spw_axil_responder dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .cfg_regs      (cfg_regs),
    .cfg_wr        (cfg_wr)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, need %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, need %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, need %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, need %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a write completes one edge after both halves are held,
  // a read samples the register array as it stood before that edge.
  logic [31:0] m_regs [4];
  logic        m_aw_have, m_w_have, m_bvalid, m_rvalid;
  logic [1:0]  m_aw_idx;
  logic [31:0] m_w_data, m_rdata;
  logic [3:0]  m_w_strb, m_cfg_wr;

  initial forever begin
    @(posedge ACLK or posedge ARESET);
    if (ARESET) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_aw_have = 0; m_w_have = 0; m_bvalid = 0; m_rvalid = 0;
      m_aw_idx = '0; m_w_data = '0; m_w_strb = '0; m_rdata = '0; m_cfg_wr = '0;
    end else begin
      logic aw_hs, w_hs, ar_hs, b_hs, r_hs, do_commit;
      aw_hs     = S_AXI_AWVALID && !m_aw_have && !m_bvalid;
      w_hs      = S_AXI_WVALID && !m_w_have && !m_bvalid;
      ar_hs     = S_AXI_ARVALID && !m_rvalid;
      b_hs      = m_bvalid && S_AXI_BREADY;
      r_hs      = m_rvalid && S_AXI_RREADY;
      do_commit = m_aw_have && m_w_have;
      m_cfg_wr  = '0;
      if (ar_hs) begin
        m_rdata  = m_regs[S_AXI_ARADDR[3:2]];
        m_rvalid = 1;
      end else if (r_hs) begin
        m_rvalid = 0;
      end
      if (do_commit) begin
        for (int k = 0; k < 4; k++)
          if (m_w_strb[k]) m_regs[m_aw_idx][8*k +: 8] = m_w_data[8*k +: 8];
        m_cfg_wr[m_aw_idx] = 1'b1;
        m_aw_have = 0;
        m_w_have  = 0;
        m_bvalid  = 1;
      end else if (b_hs) begin
        m_bvalid = 0;
      end
      if (aw_hs) begin
        m_aw_have = 1;
        m_aw_idx  = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        m_w_have = 1;
        m_w_data = S_AXI_WDATA;
        m_w_strb = S_AXI_WSTRB;
      end
    end
  end

  initial forever begin
    @(negedge ACLK);
    if (!ARESET) begin
      chk1("awready", S_AXI_AWREADY, !m_aw_have && !m_bvalid);
      chk1("wready", S_AXI_WREADY, !m_w_have && !m_bvalid);
      chk1("arready", S_AXI_ARREADY, !m_rvalid);
      chk1("bvalid", S_AXI_BVALID, m_bvalid);
      chk1("rvalid", S_AXI_RVALID, m_rvalid);
      if (m_rvalid) begin
        chk32("rdata", S_AXI_RDATA, m_rdata);
        chk4("rresp", {2'b00, S_AXI_RRESP}, 4'b0000);
      end
      if (m_bvalid) chk4("bresp", {2'b00, S_AXI_BRESP}, 4'b0000);
      chk128("cfg_regs", cfg_regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      chk4("cfg_wr", cfg_wr, m_cfg_wr);
    end
  end

  task automatic wr_start(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
  endtask

  task automatic wr_finish();
    int n;
    logic a, w, ad, wd;
    ad = 0; wd = 0; n = 0;
    S_AXI_BREADY = 1'b1;
    while (!(ad && wd) && n < 50) begin
      a = S_AXI_AWVALID && S_AXI_AWREADY;
      w = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK); n++;
      if (a) begin ad = 1; S_AXI_AWVALID = 1'b0; end
      if (w) begin wd = 1; S_AXI_WVALID = 1'b0; end
    end
    while (!S_AXI_BVALID && n < 60) begin
      @(negedge ACLK); n++;
    end
    chk1("wr_timeout", n >= 60, 1'b0);
    @(negedge ACLK);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wr_start(addr, data, strb);
    wr_finish();
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    logic hs;
    n = 0; hs = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b1;
    while (!hs && n < 20) begin
      hs = S_AXI_ARREADY;
      @(negedge ACLK); n++;
    end
    S_AXI_ARVALID = 1'b0;
    while (!S_AXI_RVALID && n < 40) begin
      @(negedge ACLK); n++;
    end
    chk1("rd_timeout", n >= 40, 1'b0);
    data = S_AXI_RDATA;
    @(negedge ACLK);
  endtask

  initial begin
    logic [31:0] rd;
    logic aw_rdy_s, w_rdy_s, ar_rdy_s;

    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk1("rst_awready", S_AXI_AWREADY, 1'b1);
    chk1("rst_wready", S_AXI_WREADY, 1'b1);
    chk1("rst_arready", S_AXI_ARREADY, 1'b1);
    chk1("rst_bvalid", S_AXI_BVALID, 1'b0);
    chk1("rst_rvalid", S_AXI_RVALID, 1'b0);
    chk32("rst_rdata", S_AXI_RDATA, 32'h0);
    chk128("rst_cfg_regs", cfg_regs, 128'h0);
    chk4("rst_cfg_wr", cfg_wr, 4'b0000);

    // Write-then-read-back of all four registers
    for (int i = 0; i < 4; i++) do_write(4'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(4 * i), rd);
      chk32("readback", rd, 32'(i + 1));
    end
    chk128("cfg_regs_all", cfg_regs, 128'h00000004_00000003_00000002_00000001);

    // W arrives three cycles ahead of AW
    S_AXI_BREADY = 1'b0;
    S_AXI_WDATA  = 32'hDEADBEEF;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    repeat (3) @(negedge ACLK);
    chk1("wfirst_no_bvalid", S_AXI_BVALID, 1'b0);
    chk32("wfirst_reg2_old", cfg_regs[95:64], 32'h3);
    S_AXI_AWADDR  = 4'h8;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    chk1("wfirst_bvalid_early", S_AXI_BVALID, 1'b0);
    @(negedge ACLK);
    chk1("wfirst_bvalid", S_AXI_BVALID, 1'b1);
    chk4("wfirst_cfg_wr", cfg_wr, 4'b0100);
    chk32("wfirst_reg2", cfg_regs[95:64], 32'hDEADBEEF);
    @(negedge ACLK);
    chk4("wfirst_cfg_wr_once", cfg_wr, 4'b0000);
    S_AXI_BREADY = 1'b1;
    repeat (2) @(negedge ACLK);

    // B held off for ten cycles while a second write is offered
    S_AXI_BREADY = 1'b0;
    wr_start(4'hC, 32'h00000055, 4'hF);
    repeat (2) @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    wr_start(4'h0, 32'h00000066, 4'hF);
    for (int i = 0; i < 10; i++) begin
      chk1("bstall_bvalid", S_AXI_BVALID, 1'b1);
      chk1("bstall_awready", S_AXI_AWREADY, 1'b0);
      chk1("bstall_wready", S_AXI_WREADY, 1'b0);
      chk32("bstall_reg0", cfg_regs[31:0], 32'h1);
      @(negedge ACLK);
    end
    wr_finish();
    chk32("bstall_reg3", cfg_regs[127:96], 32'h55);
    chk32("bstall_reg0_after", cfg_regs[31:0], 32'h66);

    // Partial strobes
    do_write(4'h0, 32'hFFFFFFFF, 4'hF);
    do_write(4'h1, 32'h12345678, 4'b0101);
    do_read(4'h0, rd);
    chk32("strobe_merge", rd, 32'hFF34FF78);
    do_write(4'h4, 32'h99999999, 4'b0000);
    do_read(4'h4, rd);
    chk32("strobe_none", rd, 32'h2);

    // Read latch and commit to the same register on one edge
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    wr_start(4'h4, 32'hAAAA5555, 4'hF);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARADDR  = 4'h4;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    chk1("collide_rvalid", S_AXI_RVALID, 1'b1);
    chk32("collide_old", S_AXI_RDATA, 32'h2);
    chk1("collide_bvalid", S_AXI_BVALID, 1'b1);
    S_AXI_RREADY = 1'b1;
    S_AXI_BREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    do_read(4'h4, rd);
    chk32("collide_new", rd, 32'hAAAA5555);

    // Reset while a read response is stalled
    S_AXI_RREADY  = 1'b0;
    S_AXI_ARADDR  = 4'h4;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    chk1("pre_rst_rvalid", S_AXI_RVALID, 1'b1);
    #2 ARESET = 1'b1;
    #1 chk1("async_rst_rvalid", S_AXI_RVALID, 1'b0);
    chk128("async_rst_cfg", cfg_regs, 128'h0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(4 * i), rd);
      chk32("post_rst_read", rd, 32'h0);
    end

    // Randomized concurrent traffic on all five channels
    aw_rdy_s = 0; w_rdy_s = 0; ar_rdy_s = 0;
    for (int c = 0; c < 3000; c++) begin
      if (S_AXI_AWVALID && aw_rdy_s) S_AXI_AWVALID = 1'b0;
      if (S_AXI_WVALID && w_rdy_s) S_AXI_WVALID = 1'b0;
      if (S_AXI_ARVALID && ar_rdy_s) S_AXI_ARVALID = 1'b0;
      if (!S_AXI_AWVALID && $urandom_range(0, 2) == 0) begin
        S_AXI_AWVALID = 1'b1;
        S_AXI_AWADDR  = 4'($urandom_range(0, 15));
      end
      if (!S_AXI_WVALID && $urandom_range(0, 2) == 0) begin
        S_AXI_WVALID = 1'b1;
        S_AXI_WDATA  = $urandom;
        S_AXI_WSTRB  = 4'($urandom_range(0, 15));
      end
      if (!S_AXI_ARVALID && $urandom_range(0, 1) == 0) begin
        S_AXI_ARVALID = 1'b1;
        S_AXI_ARADDR  = 4'($urandom_range(0, 15));
      end
      S_AXI_BREADY = ($urandom_range(0, 3) != 0);
      S_AXI_RREADY = ($urandom_range(0, 3) != 0);
      aw_rdy_s = S_AXI_AWREADY;
      w_rdy_s  = S_AXI_WREADY;
      ar_rdy_s = S_AXI_ARREADY;
      @(negedge ACLK);
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_RREADY  = 1'b1;
    repeat (6) @(negedge ACLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
